// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver feeding the 7-segment decoder.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam logic [7:0] DIGIT_LO   = 8'h30;
  localparam logic [7:0] DIGIT_HI   = 8'h39;
  localparam logic [7:0] UPPER_LO   = 8'h41;
  localparam logic [7:0] UPPER_HI   = 8'h49;
  localparam logic [7:0] LOWER_LO   = 8'h61;
  localparam logic [7:0] LOWER_HI   = 8'h69;
  localparam logic [7:0] BLANK_CODE = 8'hFF;

endpackage

// File: rtl/uart_rx_fnd_code_if.sv
// Serial line plus received-byte/symbol outputs of the UART-to-7seg receiver.
interface uart_rx_fnd_code_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] number;
  logic       char_err;
  logic       frame_err;

  modport master (
    input  rx,
    output rx_data, rx_valid, number, char_err, frame_err
  );

  modport slave (
    output rx,
    input  rx_data, rx_valid, number, char_err, frame_err
  );
endinterface

// File: rtl/ascii_to_fnd_code.sv
// Combinational ASCII-to-symbol mapping: digits 0-9, letters A-I / a-i to 0x0A-0x12.
module ascii_to_fnd_code
  import uart_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] code,
  output logic       valid
);

  always_comb begin
    code  = BLANK_CODE;
    valid = 1'b0;
    if (ascii >= DIGIT_LO && ascii <= DIGIT_HI) begin
      code  = ascii - DIGIT_LO;
      valid = 1'b1;
    end else if (ascii >= UPPER_LO && ascii <= UPPER_HI) begin
      code  = ascii - 8'h37;
      valid = 1'b1;
    end else if (ascii >= LOWER_LO && ascii <= LOWER_HI) begin
      code  = ascii - 8'h57;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fnd_code.sv
// 8N1 UART receiver; registers the raw byte and the decoder symbol code for the 7-seg driver.
module uart_rx_fnd_code
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_fnd_code_if.master   bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  state_t           state, state_nxt;
  logic             rx_meta, rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       code;
  logic             code_valid;
  logic             tick, cnt_clr, shift_en, frame_ok, frame_bad;

  ascii_to_fnd_code u_map (
    .ascii (shift_reg),
    .code  (code),
    .valid (code_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
    end
  end

  // START waits half a bit so every later sample lands at a bit centre
  assign tick = (cnt == ((state == START) ? CNT_HALF : CNT_FULL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (!rx_sync) state_nxt = START;
      START: if (tick) state_nxt = rx_sync ? IDLE : DATA;
      DATA:  if (tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (tick) state_nxt = rx_sync ? IDLE : BREAK;
      BREAK: if (rx_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    unique case (state)
      IDLE, BREAK: cnt_clr = 1'b1;
      START:       cnt_clr = tick;
      DATA: begin
        cnt_clr  = tick;
        shift_en = tick;
      end
      STOP: begin
        cnt_clr   = tick;
        frame_ok  = tick && rx_sync;
        frame_bad = tick && !rx_sync;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.number    <= BLANK_CODE;
      bus.char_err  <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (state == IDLE) bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift_reg <= {rx_sync, shift_reg[7:1]};
      bus.rx_valid  <= frame_ok;
      bus.char_err  <= frame_ok && !code_valid;
      bus.frame_err <= frame_bad;
      if (frame_ok) bus.rx_data <= shift_reg;
      if (frame_ok && code_valid) bus.number <= code;
    end
  end

endmodule
